wb_ram_arbiter: RTL and testbench

Round-robin Wishbone B3 arbiter that shares the single simulation/SoC main RAM (`wb_ram`) between several bus masters, typically the mor1kx instruction bus, data bus and the debug interface. It sits between the masters and the RAM slave port. It holds the grant for the whole bus cycle, including registered-feedback bursts. A watchdog terminates stalled cycles with an error, so a hung slave cannot lock up the CPU in simulation.

---
 rtl/wb_arb_pkg.sv | 26 ++
 rtl/wb_arb_rr_pick.sv | 47 ++++
 rtl/wb_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the Wishbone RAM arbiter
//
// Purpose: arbiter FSM state encoding, Wishbone B3 cycle-type tags and the
// index-width helper used by the arbiter and its round-robin picker.
// Ports: none (package).

package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Wishbone B3 cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Width of an encoded master index; a single bit is kept even for one master
  // so that index signals never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational round-robin request picker
//
// Purpose: selects the first active request at or after a priority pointer,
// searching upward and wrapping at N. Reusable for any shared slave.
// Ports:
//   req   in  N   request vector, bit i = requester i
//   ptr   in  IW  index searched first
//   gnt   out N   one-hot pick (all zero when nothing requests)
//   idx   out IW  encoded pick (0 when nothing requests)
//   valid out 1   at least one request present

module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [N-1:0] rot;
  logic [IW:0]  sum;

  always_comb begin
    // Rotate so that bit 0 of rot is the requester at ptr; the first set bit
    // of rot is then the winner, at distance k from ptr.
    rot   = N'({req, req} >> ptr);
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
      end
    end
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    idx = sum[IW-1:0];
    gnt = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// rtl/wb_ram_arbiter.sv - round-robin Wishbone B3 arbiter in front of main RAM
//
// Purpose: shares one Wishbone slave (the main RAM) between NUM_MASTERS bus
// masters. The grant is held for the whole bus cycle (bursts and RMW stay
// atomic); a watchdog aborts cycles stalled for TIMEOUT cycles with an error.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i      per-master address, write data, byte selects
//   m_we_i/m_cyc_i/m_stb_i       per-master controls (one bit per master)
//   m_cti_i/m_bte_i              per-master burst tags
//   m_dat_o                      slave read data, broadcast to all masters
//   m_ack_o/m_err_o              per-master termination
//   s_*_o                        granted master's request towards the slave
//   s_dat_i/s_ack_i/s_err_i      slave response
//   grant_o                      one-hot current owner

module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = idx_width(N);

  arb_state_e    state;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] ptr;
  logic [31:0]   wdt;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic          busy;
  logic          aborting;
  logic [IW-1:0] ptr_next;
  logic          stall;
  logic          expire;

  // Granted master's request, selected by the registered index.
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [3:0]    g_sel;
  logic          g_we;
  logic          g_cyc;
  logic          g_stb;
  logic [2:0]    g_cti;
  logic [1:0]    g_bte;

  wb_arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (m_cyc_i),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_cti = CTI_CLASSIC;
    g_bte = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        g_adr = m_adr_i[i*AW +: AW];
        g_dat = m_dat_i[i*DW +: DW];
        g_sel = m_sel_i[i*4 +: 4];
        g_we  = m_we_i[i];
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        g_cti = m_cti_i[i*3 +: 3];
        g_bte = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign busy     = (state == ST_BUSY);
  assign aborting = (state == ST_ABORT);

  // Control lines are only driven in BUSY; IDLE, ABORT and reset all present
  // an idle bus to the slave. Address and data are don't-care without stb.
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = busy ? g_sel : 4'h0;
  assign s_we_o  = busy & g_we;
  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;
  assign s_cti_o = busy ? g_cti : CTI_CLASSIC;
  assign s_bte_o = busy ? g_bte : 2'b00;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = busy ? (grant & {N{s_ack_i}}) : '0;
  // During the single ABORT cycle the owner is terminated with an error.
  assign m_err_o = busy ? (grant & {N{s_err_i}}) : (aborting ? grant : '0);
  assign grant_o = grant;

  assign ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
  assign stall    = s_stb_o & ~s_ack_i & ~s_err_i;
  // A termination in the expiring cycle clears stall, so ack beats the abort.
  assign expire   = (TIMEOUT != 0) && stall && (wdt == 32'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      wdt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wdt <= '0;
          if (pick_valid) begin
            grant     <= pick_gnt;
            grant_idx <= pick_idx;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            ptr   <= ptr_next;
            grant <= '0;
            wdt   <= '0;
            state <= ST_IDLE;
          end else if (expire) begin
            wdt   <= '0;
            state <= ST_ABORT;
          end else if (stall && (TIMEOUT != 0)) begin
            wdt <= wdt + 32'd1;
          end else begin
            wdt <= '0;
          end
        end
        ST_ABORT: begin
          ptr   <= ptr_next;
          grant <= '0;
          wdt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb/tb_wb_ram_arbiter.sv - self-checking bench for wb_ram_arbiter

module tb_wb_ram_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   m_adr_i;
  logic [63:0]   m_dat_i;
  logic [7:0]    m_sel_i;
  logic [1:0]    m_we_i;
  logic [1:0]    m_cyc_i;
  logic [1:0]    m_stb_i;
  logic [5:0]    m_cti_i;
  logic [3:0]    m_bte_i;
  logic [31:0]   m_dat_o;
  logic [1:0]    m_ack_o;
  logic [1:0]    m_err_o;
  logic [31:0]   s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i;
  logic          s_err_i;
  logic [1:0]    grant_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .NUM_MASTERS (N),
    .AW          (32),
    .DW          (32),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_cti_i   (m_cti_i),
    .m_bte_i   (m_bte_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .grant_o   (grant_o)
  );

  // Registered RAM model: acks ack_lat cycles after stb (-1 = never).
  logic [31:0] mem [0:1023];
  int          ack_lat = 0;
  int          stall;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic [3:0]  log_sel [0:63];
  logic        log_we  [0:63];
  int          log_n = 0;
  int          ack_cnt [2] = '{0, 0};

  assign s_err_i = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_i <= 1'b0;
      stall   <= 0;
    end else begin
      s_ack_i <= 1'b0;
      if (s_cyc_o && s_stb_o && !s_ack_i) begin
        if (ack_lat >= 0 && stall >= ack_lat) begin
          s_ack_i <= 1'b1;
          stall   <= 0;
          if (s_we_o) mem[s_adr_o[11:2]] <= s_dat_o;
          s_dat_i <= mem[s_adr_o[11:2]];
          log_adr[log_n % 64] <= s_adr_o;
          log_dat[log_n % 64] <= s_dat_o;
          log_sel[log_n % 64] <= s_sel_o;
          log_we[log_n % 64]  <= s_we_o;
          log_n <= log_n + 1;
        end else begin
          stall <= stall + 1;
        end
      end else begin
        stall <= 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_ack_o[i]) ack_cnt[i] <= ack_cnt[i] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input bit cyc, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [2:0] cti);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = cyc;
    m_we_i[m]           = we;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = dat;
    m_sel_i[m*4 +: 4]   = cyc ? 4'hF : 4'h0;
    m_cti_i[m*3 +: 3]   = cti;
    m_bte_i[m*2 +: 2]   = 2'b00;
  endtask

  task automatic release_m(input int m);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
  endtask

  // Returns at the negedge of the cycle in which master m sees ack; lat counts
  // cycles from the cycle the task was entered in (-1 if the bound expires).
  task automatic wait_ack(input int m, input int max, output int lat);
    lat = -1;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (m_ack_o[m]) begin
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat;
    int          snap [2];
    int          base;
    logic [31:0] rd;
    logic [1:0]  g;
    int          w;

    vecs[0] = '{0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 32'h104, 32'h12345678, 32'h0};
    vecs[3] = '{1, 1'b0, 32'h104, 32'h0,        32'h12345678};
    vecs[4] = '{0, 1'b0, 32'h104, 32'h0,        32'h12345678};
    vecs[5] = '{1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};

    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;

    // Reset state, during and after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_ack", m_ack_o, 0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_s_cyc", s_cyc_o, 0);
    chk("post_rst_err", m_err_o, 0);
    chk("post_rst_grant", grant_o, 0);

    // Single-master transactions from the table
    for (int v = 0; v < 6; v++) begin
      tick();
      snap = ack_cnt;
      drive(vecs[v].m, 1'b1, vecs[v].we, vecs[v].adr, vecs[v].dat, CTI_CLASSIC);
      wait_ack(vecs[v].m, 20, lat);
      rd = m_dat_o;
      chk($sformatf("v%0d_latency", v), lat, 2);
      if (vecs[v].we) begin
        chk($sformatf("v%0d_slave_adr", v), log_adr[(log_n - 1) % 64], vecs[v].adr);
        chk($sformatf("v%0d_slave_dat", v), log_dat[(log_n - 1) % 64], vecs[v].dat);
        chk($sformatf("v%0d_slave_sel", v), log_sel[(log_n - 1) % 64], 4'hF);
        chk($sformatf("v%0d_slave_we", v), log_we[(log_n - 1) % 64], 1);
      end else begin
        chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      end
      tick();
      release_m(vecs[v].m);
      chk($sformatf("v%0d_own_acks", v), ack_cnt[vecs[v].m], snap[vecs[v].m] + 1);
      chk($sformatf("v%0d_other_acks", v), ack_cnt[1 - vecs[v].m], snap[1 - vecs[v].m]);
    end

    // Contention after reset-equivalent pointer (ptr=0): m0 first, m1 two cycles after release
    tick();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    drive(1, 1'b1, 1'b0, 32'h104, 32'h0, CTI_CLASSIC);
    @(negedge clk);
    chk("cont_n_grant", grant_o, 2'b00);
    tick(); @(negedge clk);
    chk("cont_n1_grant", grant_o, 2'b01);
    chk("cont_n1_adr", s_adr_o, 32'h100);
    tick(); @(negedge clk);
    chk("cont_m0_ack", m_ack_o, 2'b01);
    chk("cont_m0_data", m_dat_o, 32'hDEADBEEF);
    tick(); release_m(0); @(negedge clk);
    chk("cont_k_grant", grant_o, 2'b01);
    tick(); @(negedge clk);
    chk("cont_k1_grant", grant_o, 2'b00);
    tick(); @(negedge clk);
    chk("cont_k2_grant", grant_o, 2'b10);
    tick(); @(negedge clk);
    chk("cont_m1_ack", m_ack_o, 2'b10);
    chk("cont_m1_data", m_dat_o, 32'h12345678);
    tick(); release_m(1);

    // Four contended rounds; the winner of each releases, the loser withdraws
    for (int r = 0; r < 4; r++) begin
      tick();
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
      drive(1, 1'b1, 1'b0, 32'h104, 32'h0, CTI_CLASSIC);
      g = 2'b00;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (grant_o != 2'b00) begin
          g = grant_o;
          break;
        end
        tick();
      end
      chk($sformatf("round%0d_grant", r), g, (r % 2 == 0) ? 2'b01 : 2'b10);
      w = (g == 2'b10) ? 1 : 0;
      wait_ack(w, 20, lat);
      chk($sformatf("round%0d_acked", r), lat >= 0, 1);
      tick();
      release_m(0);
      release_m(1);
    end

    // Burst atomicity: m1 4-beat incrementing write burst, m0 requests mid-burst
    tick();
    base = log_n;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      drive(1, 1'b1, 1'b1, 32'h200 + 32'(4 * b), 32'hB000_0000 + 32'(b),
            (b == 3) ? CTI_END : CTI_INCR);
      if (b == 1) drive(0, 1'b1, 1'b0, 32'h20C, 32'h0, CTI_CLASSIC);
      wait_ack(1, 20, lat);
      chk($sformatf("burst_b%0d_ack", b), lat >= 0, 1);
      chk($sformatf("burst_b%0d_grant", b), grant_o, 2'b10);
      chk($sformatf("burst_b%0d_m0_ack", b), m_ack_o[0], 0);
    end
    tick(); release_m(1); @(negedge clk);
    chk("burst_k_grant", grant_o, 2'b10);
    tick(); @(negedge clk);
    chk("burst_k1_grant", grant_o, 2'b00);
    tick(); @(negedge clk);
    chk("burst_k2_grant", grant_o, 2'b01);
    wait_ack(0, 20, lat);
    chk("burst_m0_rdata", m_dat_o, 32'hB000_0003);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("burst_log_adr%0d", b), log_adr[(base + b) % 64], 32'h200 + 32'(4 * b));
    end
    chk("burst_log_count", log_n - base, 5);
    tick(); release_m(0);

    // Watchdog: slave never acks
    ack_lat = -1;
    tick();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    for (int i = 1; i <= 17; i++) begin
      tick(); @(negedge clk);
      if (i == 1)  chk("wdt_first_stb", s_stb_o, 1);
      if (i == 16) chk("wdt_no_err_yet", m_err_o, 2'b00);
      if (i == 16) chk("wdt_stb_held", s_stb_o, 1);
      if (i == 17) chk("wdt_err", m_err_o, 2'b01);
      if (i == 17) chk("wdt_cyc_low", s_cyc_o, 0);
    end
    tick(); release_m(0); @(negedge clk);
    chk("wdt_idle_grant", grant_o, 2'b00);
    chk("wdt_idle_err", m_err_o, 2'b00);

    // Ack race: ack lands in the cycle the watchdog would expire
    ack_lat = TO - 2;
    tick();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CTI_CLASSIC);
    for (int i = 1; i <= 16; i++) begin
      tick(); @(negedge clk);
      if (i == 15) chk("race_no_early_ack", m_ack_o, 2'b00);
      if (i == 16) chk("race_ack", m_ack_o, 2'b01);
      if (i == 16) chk("race_no_err", m_err_o, 2'b00);
      if (i == 16) chk("race_data", m_dat_o, 32'hDEADBEEF);
    end
    tick(); release_m(0); @(negedge clk);
    chk("race_no_abort", m_err_o, 2'b00);
    chk("race_grant_held", grant_o, 2'b01);
    ack_lat = 0;

    // Reset during beat 2 of an m1 burst
    tick();
    drive(1, 1'b1, 1'b1, 32'h200, 32'h11, CTI_INCR);
    wait_ack(1, 20, lat);
    tick();
    drive(1, 1'b1, 1'b1, 32'h204, 32'h22, CTI_INCR);
    wait_ack(1, 20, lat);
    chk("rst_pre_ack", m_ack_o, 2'b10);
    drive(0, 1'b1, 1'b0, 32'h300, 32'h0, CTI_CLASSIC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", s_cyc_o, 0);
    chk("rst_async_grant", grant_o, 2'b00);
    chk("rst_async_ack", m_ack_o, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); @(negedge clk);
    chk("rst_after_grant", grant_o, 2'b01);
    chk("rst_after_adr", s_adr_o, 32'h300);
    tick(); release_m(0); release_m(1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
